// File: rtl/ahb_ic_pkg.sv
// Shared types and constants for the AHB interconnect: FSM encoding,
// error cause codes, HTRANS encodings and the default-slave read pattern.
package ahb_ic_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_ERR1   = 2'b01,
        ST_ERR2   = 2'b10
    } ic_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] AHB_BAD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ahb_interconnect_if.sv
// AHB bus bundle between one master, NSLV slaves and the interconnect.
// master: environment side (master plus slaves); slave: interconnect side.
interface ahb_interconnect_if #(
    parameter int unsigned NSLV = 5
);
    logic [31:0]        HADDR;
    logic [1:0]         HTRANS;
    logic [NSLV-1:0]    HSEL;
    logic [NSLV*32-1:0] HRDATA_S;
    logic [NSLV-1:0]    HREADYOUT_S;
    logic [NSLV-1:0]    HRESP_S;
    logic [31:0]        HRDATA;
    logic               HREADY;
    logic               HRESP;

    modport master (
        output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HSEL, HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HSEL, HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_err_slave.sv
// Default slave and stall watchdog: error-response FSM, stall counter and
// sticky error status. override_o tells the top to use this block's response.
module ahb_err_slave
    import ahb_ic_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        def_sel_i,
    input  logic        active_i,
    input  logic        slv_ready_i,
    input  logic [31:0] addr_i,
    input  logic        err_clr_i,
    output logic        override_o,
    output logic        hready_o,
    output logic        hresp_o,
    output logic        err_flag_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] err_addr_o
);
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

    ic_state_e   state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic        err_flag_q, err_flag_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        stall, timeout, unmapped;

    always_comb begin
        state_d    = state_q;
        stall_d    = '0;
        err_flag_d = err_flag_q;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        override_o = 1'b1;
        hready_o   = 1'b1;
        hresp_o    = 1'b0;
        stall      = 1'b0;
        timeout    = 1'b0;
        unmapped   = 1'b0;
        if (err_clr_i) begin
            err_flag_d = 1'b0;
            err_code_d = ERR_NONE;
        end
        unique case (state_q)
            ST_NORMAL: begin
                if (def_sel_i) begin
                    // Active access to unmapped space: one wait state before ERR1.
                    unmapped = active_i;
                    hready_o = !active_i;
                end else begin
                    override_o = 1'b0;
                    stall      = active_i && !slv_ready_i;
                    timeout    = stall && (stall_q == STALL_LAST);
                    if (stall) stall_d = stall_q + 16'd1;
                end
                if (unmapped || timeout) begin
                    state_d    = ST_ERR1;
                    err_flag_d = 1'b1;
                    err_code_d = unmapped ? ERR_UNMAPPED : ERR_TIMEOUT;
                    err_addr_d = addr_i;
                end
            end
            ST_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = 1'b1;
                state_d  = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o = 1'b1;
                state_d = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_NORMAL;
            stall_q    <= '0;
            err_flag_q <= 1'b0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_flag_o = err_flag_q;
    assign err_code_o = err_code_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB interconnect: combinational address decode, data-phase
// select register and zero-latency response mux, with an error/timeout slave.
module ahb_interconnect
    import ahb_ic_pkg::*;
#(
    parameter int unsigned        NSLV     = 5,
    parameter logic [NSLV*32-1:0] SLV_BASE = {32'h5200_0000, 32'h5100_0000, 32'h5000_0000,
                                              32'h2000_0000, 32'h0000_0000},
    parameter logic [NSLV*32-1:0] SLV_MASK = {32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
                                              32'hF000_0000, 32'hF000_0000},
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [31:0]        BAD_DATA = AHB_BAD_DATA
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_interconnect_if.slave  bus,
    input  logic               err_clr,
    output logic               err_flag,
    output logic [1:0]         err_code,
    output logic [31:0]        err_addr
);
    localparam int unsigned IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic             addr_active;
    logic             sel_hit_q, active_q;
    logic [IDX_W-1:0] sel_idx_q;
    logic [31:0]      addr_q;
    logic [31:0]      slv_rdata;
    logic             slv_ready, slv_resp;
    logic             es_override, es_ready, es_resp;

    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        bus.HSEL = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!dec_hit && ((bus.HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
        if (dec_hit) bus.HSEL[dec_idx] = 1'b1;
    end

    assign addr_active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_hit_q <= 1'b0;
            sel_idx_q <= '0;
            active_q  <= 1'b0;
            addr_q    <= '0;
        end else if (bus.HREADY) begin
            sel_hit_q <= dec_hit;
            sel_idx_q <= dec_idx;
            active_q  <= addr_active;
            addr_q    <= bus.HADDR;
        end
    end

    assign slv_rdata = bus.HRDATA_S[32*sel_idx_q +: 32];
    assign slv_ready = bus.HREADYOUT_S[sel_idx_q];
    assign slv_resp  = bus.HRESP_S[sel_idx_q];

    ahb_err_slave #(
        .TIMEOUT (TIMEOUT)
    ) u_err_slave (
        .clk_i       (HCLK),
        .rst_i       (HRESET),
        .def_sel_i   (!sel_hit_q),
        .active_i    (active_q),
        .slv_ready_i (slv_ready),
        .addr_i      (addr_q),
        .err_clr_i   (err_clr),
        .override_o  (es_override),
        .hready_o    (es_ready),
        .hresp_o     (es_resp),
        .err_flag_o  (err_flag),
        .err_code_o  (err_code),
        .err_addr_o  (err_addr)
    );

    assign bus.HRDATA = es_override ? BAD_DATA : slv_rdata;
    assign bus.HREADY = es_override ? es_ready : slv_ready;
    assign bus.HRESP  = es_override ? es_resp  : slv_resp;

endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed bench for ahb_interconnect: a per-cycle vector table followed by
// hand-written error, timeout and reset-abort sequences.
module tb_ahb_interconnect;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [4:0]  rdy;
        logic [4:0]  resp;
        logic        clr;
        logic [4:0]  e_hsel;
        logic [31:0] e_rdata;
        logic        e_ready;
        logic        e_resp;
        logic        e_flag;
        logic [1:0]  e_code;
        logic [31:0] e_eaddr;
    } vec_t;

    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
    localparam logic [31:0] D0  = 32'h0000_1000;
    localparam logic [31:0] D1  = 32'h1234_5678;
    localparam logic [31:0] D2  = 32'h2222_2222;
    localparam logic [31:0] D3  = 32'h3333_3333;
    localparam logic [31:0] D4  = 32'h4444_4444;
    localparam logic [1:0]  IDL = 2'b00;
    localparam logic [1:0]  BSY = 2'b01;
    localparam logic [1:0]  NSQ = 2'b10;
    localparam logic [4:0]  ALL = 5'b11111;

    logic        HCLK;
    logic        HRESET;
    logic        err_clr;
    logic        err_flag;
    logic [1:0]  err_code;
    logic [31:0] err_addr;

    int total = 0;
    int bad   = 0;

    ahb_interconnect_if #(.NSLV(5)) bus ();

    ahb_interconnect #(
        .NSLV    (5),
        .TIMEOUT (4)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .bus      (bus),
        .err_clr  (err_clr),
        .err_flag (err_flag),
        .err_code (err_code),
        .err_addr (err_addr)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [4:0] r,
                         input logic [4:0] rs, input logic c);
        bus.HADDR       = a;
        bus.HTRANS      = t;
        bus.HREADYOUT_S = r;
        bus.HRESP_S     = rs;
        err_clr         = c;
    endtask

    // Drive just after the rising edge, then wait for the falling edge to sample.
    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [4:0] r,
                        input logic [4:0] rs, input logic c);
        @(posedge HCLK);
        #1;
        drive(a, t, r, rs, c);
        @(negedge HCLK);
    endtask

    vec_t vq[$];

    initial begin
        // addr, trans, rdy, resp, clr | hsel, rdata, ready, resp, flag, code, err_addr
        vq.push_back(vec_t'{32'h2000_0010, NSQ, ALL, 5'b0, 1'b0, 5'b00010, BAD, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h0000_0040, IDL, ALL, 5'b0, 1'b0, 5'b00001, D1,  1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h5100_0004, NSQ, ALL, 5'b0, 1'b0, 5'b01000, D0,  1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h5000_0000, NSQ, 5'b10111, 5'b0, 1'b0, 5'b00100, D3, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h5000_0000, NSQ, ALL, 5'b01000, 1'b0, 5'b00100, D3, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h5200_0000, NSQ, ALL, 5'b0, 1'b0, 5'b10000, D2,  1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h9000_0000, IDL, ALL, 5'b0, 1'b0, 5'b00000, D4,  1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h9000_0000, IDL, ALL, 5'b0, 1'b0, 5'b00000, BAD, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h9000_0000, BSY, ALL, 5'b0, 1'b0, 5'b00000, BAD, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h0000_0000, IDL, ALL, 5'b0, 1'b0, 5'b00001, BAD, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h1FFF_FFFF, IDL, ALL, 5'b0, 1'b0, 5'b00000, D0,  1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h50FF_FFFC, IDL, ALL, 5'b0, 1'b0, 5'b00100, BAD, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h5300_0000, IDL, ALL, 5'b0, 1'b0, 5'b00000, D2,  1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h9000_0000, NSQ, ALL, 5'b0, 1'b0, 5'b00000, BAD, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h0000_0100, NSQ, ALL, 5'b0, 1'b0, 5'b00001, BAD, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0});
        vq.push_back(vec_t'{32'h0000_0100, NSQ, ALL, 5'b0, 1'b0, 5'b00001, BAD, 1'b0, 1'b1, 1'b1, 2'b01, 32'h9000_0000});
        vq.push_back(vec_t'{32'h0000_0100, NSQ, ALL, 5'b0, 1'b0, 5'b00001, BAD, 1'b1, 1'b1, 1'b1, 2'b01, 32'h9000_0000});
        vq.push_back(vec_t'{32'h0000_0000, IDL, ALL, 5'b0, 1'b1, 5'b00001, D0,  1'b1, 1'b0, 1'b1, 2'b01, 32'h9000_0000});
        vq.push_back(vec_t'{32'h9000_0000, IDL, ALL, 5'b0, 1'b0, 5'b00000, D0,  1'b1, 1'b0, 1'b0, 2'b00, 32'h9000_0000});

        bus.HRDATA_S = {D4, D3, D2, D1, D0};
        drive(32'h9000_0000, IDL, ALL, 5'b0, 1'b0);
        HRESET = 1'b1;
        @(posedge HCLK);
        @(posedge HCLK);
        @(negedge HCLK);
        chk("rst hready", 32'(bus.HREADY), 32'h1);
        chk("rst hresp",  32'(bus.HRESP),  32'h0);
        chk("rst hrdata", bus.HRDATA,      BAD);
        chk("rst hsel",   32'(bus.HSEL),   32'h0);
        chk("rst flag",   32'(err_flag),   32'h0);
        chk("rst code",   32'(err_code),   32'h0);
        chk("rst eaddr",  err_addr,        32'h0);
        HRESET = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].addr, vq[i].trans, vq[i].rdy, vq[i].resp, vq[i].clr);
            chk($sformatf("v%0d hsel", i),   32'(bus.HSEL),   32'(vq[i].e_hsel));
            chk($sformatf("v%0d hrdata", i), bus.HRDATA,      vq[i].e_rdata);
            chk($sformatf("v%0d hready", i), 32'(bus.HREADY), 32'(vq[i].e_ready));
            chk($sformatf("v%0d hresp", i),  32'(bus.HRESP),  32'(vq[i].e_resp));
            chk($sformatf("v%0d flag", i),   32'(err_flag),   32'(vq[i].e_flag));
            chk($sformatf("v%0d code", i),   32'(err_code),   32'(vq[i].e_code));
            chk($sformatf("v%0d eaddr", i),  err_addr,        vq[i].e_eaddr);
        end

        // err_clr in the same cycle as ERR1 entry: the new error must win
        step(32'h5300_0000, NSQ, ALL, 5'b0, 1'b0);
        chk("clr a1 hready", 32'(bus.HREADY), 32'h1);
        step(32'h2000_0000, NSQ, ALL, 5'b0, 1'b1);
        chk("clr a2 hready", 32'(bus.HREADY), 32'h0);
        chk("clr a2 hresp",  32'(bus.HRESP),  32'h0);
        step(32'h2000_0000, NSQ, ALL, 5'b0, 1'b0);
        chk("clr a3 hready", 32'(bus.HREADY), 32'h0);
        chk("clr a3 hresp",  32'(bus.HRESP),  32'h1);
        chk("clr a3 flag",   32'(err_flag),   32'h1);
        chk("clr a3 code",   32'(err_code),   32'h1);
        chk("clr a3 eaddr",  err_addr,        32'h5300_0000);
        step(32'h2000_0000, NSQ, ALL, 5'b0, 1'b0);
        chk("clr a4 hready", 32'(bus.HREADY), 32'h1);
        chk("clr a4 hresp",  32'(bus.HRESP),  32'h1);
        step(32'h9000_0000, IDL, ALL, 5'b0, 1'b0);
        chk("clr a5 hrdata", bus.HRDATA,      D1);
        chk("clr a5 hready", 32'(bus.HREADY), 32'h1);
        chk("clr a5 hresp",  32'(bus.HRESP),  32'h0);

        // Stall timeout with TIMEOUT=4 on slave 2
        step(32'h5000_0020, NSQ, ALL, 5'b0, 1'b0);
        chk("to b0 hready", 32'(bus.HREADY), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step(32'h0000_0000, NSQ, 5'b11011, 5'b0, 1'b0);
            chk($sformatf("to stall%0d hready", k), 32'(bus.HREADY), 32'h0);
            chk($sformatf("to stall%0d hresp", k),  32'(bus.HRESP),  32'h0);
        end
        step(32'h0000_0000, NSQ, 5'b11011, 5'b0, 1'b0);
        chk("to err1 hready", 32'(bus.HREADY), 32'h0);
        chk("to err1 hresp",  32'(bus.HRESP),  32'h1);
        chk("to err1 flag",   32'(err_flag),   32'h1);
        chk("to err1 code",   32'(err_code),   32'h2);
        chk("to err1 eaddr",  err_addr,        32'h5000_0020);
        step(32'h0000_0000, NSQ, 5'b11011, 5'b0, 1'b0);
        chk("to err2 hready", 32'(bus.HREADY), 32'h1);
        chk("to err2 hresp",  32'(bus.HRESP),  32'h1);
        step(32'h9000_0000, IDL, ALL, 5'b0, 1'b0);
        chk("to next hrdata", bus.HRDATA,      D0);
        chk("to next hready", 32'(bus.HREADY), 32'h1);
        chk("to next hresp",  32'(bus.HRESP),  32'h0);
        chk("to next code",   32'(err_code),   32'h2);

        // Reset asserted in the middle of ERR1
        step(32'h9000_0000, NSQ, ALL, 5'b0, 1'b0);
        step(32'h9000_0000, IDL, ALL, 5'b0, 1'b0);
        chk("rst c2 hready", 32'(bus.HREADY), 32'h0);
        step(32'h9000_0000, IDL, ALL, 5'b0, 1'b0);
        chk("rst c3 hready", 32'(bus.HREADY), 32'h0);
        chk("rst c3 hresp",  32'(bus.HRESP),  32'h1);
        chk("rst c3 flag",   32'(err_flag),   32'h1);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst c4 hready", 32'(bus.HREADY), 32'h1);
        chk("rst c4 hresp",  32'(bus.HRESP),  32'h0);
        chk("rst c4 hrdata", bus.HRDATA,      BAD);
        chk("rst c4 flag",   32'(err_flag),   32'h0);
        chk("rst c4 code",   32'(err_code),   32'h0);
        chk("rst c4 eaddr",  err_addr,        32'h0);
        step(32'h9000_0000, IDL, ALL, 5'b0, 1'b0);
        chk("rst c5 hready", 32'(bus.HREADY), 32'h1);
        chk("rst c5 hresp",  32'(bus.HRESP),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
